// File: rtl/pbus_host_regs_pkg.sv
// Shared address map, CTRL bit indices and STATUS bit positions for the PBus host register bank.
package pbus_host_regs_pkg;

    localparam int ADDR_CTRL   = 0;
    localparam int ADDR_STATUS = 1;
    localparam int ADDR_ARG0   = 2;
    localparam int ADDR_ARG1   = 3;
    localparam int ADDR_RESULT = 4;

    localparam int CTRL_START  = 0;
    localparam int CTRL_FLUSH  = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int ST_BUSY      = 0;
    localparam int ST_DONE      = 1;
    localparam int ST_EMPTY     = 2;
    localparam int ST_FULL      = 3;
    localparam int ST_UNDERFLOW = 4;
    localparam int ST_COUNT_LSB = 8;

    // Occupancy counter needs one bit more than the pointers to represent "full".
    function automatic int count_width(int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pbus_host_regs_if.sv
// PBus-side strobes, address and data between the handshake interface and the register bank.
interface pbus_host_regs_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16
) ();
    logic              RD;
    logic              WR;
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] DataIn;
    logic [DATA_W-1:0] DataOut;

    modport master (output RD, output WR, output Addr, output DataIn, input DataOut);
    modport slave  (input RD, input WR, input Addr, input DataIn, output DataOut);
endinterface

// File: rtl/pbus_result_fifo.sv
// Single-clock result FIFO with synchronous flush, registered pointers and an occupancy count.
module pbus_result_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [DATA_W-1:0]      push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [DATA_W-1:0]      head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push & ~full & ~flush;
        do_pop   = pop & ~empty & ~flush;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/pbus_host_regs.sv
// Host register bank behind the PBus handshake: CTRL/STATUS/ARG registers and a drained result FIFO.
// Optional PBUS_HOST_REGS_IRQ_EN adds a stored irq_en bit in CTRL and an Irq output.
module pbus_host_regs
    import pbus_host_regs_pkg::*;
#(
    parameter int ADDR_W     = 3,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    pbus_host_regs_if.slave   bus,
    output logic              Start,
    output logic [DATA_W-1:0] Arg0,
    output logic [DATA_W-1:0] Arg1,
    input  logic              Busy,
    input  logic              ResValid,
    input  logic [DATA_W-1:0] ResData,
    output logic              ResReady
`ifdef PBUS_HOST_REGS_IRQ_EN
    ,
    output logic              Irq
`endif
);
    localparam int CNT_W = count_width(FIFO_DEPTH);

    logic              rd_d_q, rd_d_d;
    logic              busy_d_q, busy_d_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              start_q, start_d;
    logic [DATA_W-1:0] arg0_q, arg0_d;
    logic [DATA_W-1:0] arg1_q, arg1_d;
    logic              done_q, done_d;
    logic              underflow_q, underflow_d;

    logic              rd_first;
    logic              is_ctrl, is_arg0, is_arg1, is_result;
    logic              ctrl_wr, start_ok, flush;
    logic              fifo_push, fifo_pop, underflow_hit, done_set;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

`ifdef PBUS_HOST_REGS_IRQ_EN
    logic irq_en_q, irq_en_d;
    assign Irq = done_q & irq_en_q;
`endif

    assign is_ctrl   = (bus.Addr == ADDR_W'(ADDR_CTRL));
    assign is_arg0   = (bus.Addr == ADDR_W'(ADDR_ARG0));
    assign is_arg1   = (bus.Addr == ADDR_W'(ADDR_ARG1));
    assign is_result = (bus.Addr == ADDR_W'(ADDR_RESULT));

    // A write in the same cycle as a read wins; the read is dropped entirely.
    assign rd_first      = bus.RD & ~rd_d_q & ~bus.WR;
    assign ctrl_wr       = bus.WR & is_ctrl;
    assign start_ok      = ctrl_wr & bus.DataIn[CTRL_START] & ~Busy;
    assign flush         = ctrl_wr & bus.DataIn[CTRL_FLUSH];
    assign fifo_push     = ResValid & ResReady;
    assign fifo_pop      = rd_first & is_result & ~fifo_empty;
    assign underflow_hit = rd_first & is_result & fifo_empty;
    assign done_set      = busy_d_q & ~Busy;

    assign ResReady    = ~fifo_full;
    assign Start       = start_q;
    assign Arg0        = arg0_q;
    assign Arg1        = arg1_q;
    assign bus.DataOut = data_out_q;

    always_comb begin
        rdata = '0;
        case (bus.Addr)
`ifdef PBUS_HOST_REGS_IRQ_EN
            ADDR_W'(ADDR_CTRL):   rdata[CTRL_IRQ_EN] = irq_en_q;
`endif
            ADDR_W'(ADDR_STATUS): begin
                rdata[ST_BUSY]                  = Busy;
                rdata[ST_DONE]                  = done_q;
                rdata[ST_EMPTY]                 = fifo_empty;
                rdata[ST_FULL]                  = fifo_full;
                rdata[ST_UNDERFLOW]             = underflow_q;
                rdata[ST_COUNT_LSB +: CNT_W]    = fifo_count;
            end
            ADDR_W'(ADDR_ARG0):   rdata = arg0_q;
            ADDR_W'(ADDR_ARG1):   rdata = arg1_q;
            ADDR_W'(ADDR_RESULT): rdata = fifo_empty ? '0 : fifo_head;
            default:              rdata = '0;
        endcase
    end

    always_comb begin
        rd_d_d      = bus.RD;
        busy_d_d    = Busy;
        data_out_d  = rd_first ? rdata : data_out_q;
        start_d     = start_ok;
        arg0_d      = (bus.WR & is_arg0) ? bus.DataIn : arg0_q;
        arg1_d      = (bus.WR & is_arg1) ? bus.DataIn : arg1_q;
        // Set has priority over clear when a Busy fall meets a start or flush.
        if (done_set)
            done_d = 1'b1;
        else if (start_ok | flush)
            done_d = 1'b0;
        else
            done_d = done_q;
        if (underflow_hit)
            underflow_d = 1'b1;
        else if (flush)
            underflow_d = 1'b0;
        else
            underflow_d = underflow_q;
`ifdef PBUS_HOST_REGS_IRQ_EN
        irq_en_d = ctrl_wr ? bus.DataIn[CTRL_IRQ_EN] : irq_en_q;
`endif
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_d_q      <= 1'b0;
            busy_d_q    <= 1'b0;
            data_out_q  <= '0;
            start_q     <= 1'b0;
            arg0_q      <= '0;
            arg1_q      <= '0;
            done_q      <= 1'b0;
            underflow_q <= 1'b0;
`ifdef PBUS_HOST_REGS_IRQ_EN
            irq_en_q    <= 1'b0;
`endif
        end else begin
            rd_d_q      <= rd_d_d;
            busy_d_q    <= busy_d_d;
            data_out_q  <= data_out_d;
            start_q     <= start_d;
            arg0_q      <= arg0_d;
            arg1_q      <= arg1_d;
            done_q      <= done_d;
            underflow_q <= underflow_d;
`ifdef PBUS_HOST_REGS_IRQ_EN
            irq_en_q    <= irq_en_d;
`endif
        end
    end

    pbus_result_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (Clk),
        .rst       (Reset),
        .push      (fifo_push),
        .push_data (ResData),
        .pop       (fifo_pop),
        .flush     (flush),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_pbus_host_regs.sv
// Directed bench for pbus_host_regs: reads, writes, FIFO order/limits, flags and start/done handshake.
module tb_pbus_host_regs;
    import pbus_host_regs_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] arg0, arg1;
    logic        busy;
    logic        res_valid;
    logic [15:0] res_data;
    logic        res_ready;
    int          checks;
    int          errors;

`ifdef PBUS_HOST_REGS_IRQ_EN
    logic        irq;
    localparam logic [15:0] CTRL_RB = 16'h0004;
`else
    localparam logic [15:0] CTRL_RB = 16'h0000;
`endif

    pbus_host_regs_if #(.ADDR_W(3), .DATA_W(16)) bus ();

    pbus_host_regs #(.ADDR_W(3), .DATA_W(16), .FIFO_DEPTH(8)) dut (
        .Clk      (clk),
        .Reset    (rst),
        .bus      (bus),
        .Start    (start),
        .Arg0     (arg0),
        .Arg1     (arg1),
        .Busy     (busy),
        .ResValid (res_valid),
        .ResData  (res_data),
        .ResReady (res_ready)
`ifdef PBUS_HOST_REGS_IRQ_EN
        ,
        .Irq      (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input logic [15:0] data);
        bus.Addr   = 3'(addr);
        bus.DataIn = data;
        bus.WR     = 1'b1;
        tick();
        bus.WR     = 1'b0;
    endtask

    // Read with RD held for `cycles`; data must appear after the first edge and hold afterwards.
    task automatic rd_chk(input string tag, input int addr, input int cycles, input logic [15:0] exp);
        bus.Addr = 3'(addr);
        bus.RD   = 1'b1;
        tick();
        chk(tag, bus.DataOut, exp);
        repeat (cycles - 1) tick();
        bus.RD = 1'b0;
        tick();
        chk({tag, "_hold"}, bus.DataOut, exp);
    endtask

    task automatic push_word(input logic [15:0] data);
        res_valid = 1'b1;
        res_data  = data;
        tick();
        res_valid = 1'b0;
    endtask

    // Two-cycle RESULT read with a result offered on the first (pop) cycle.
    task automatic rd_push(input string tag, input logic [15:0] push_val, input logic [15:0] exp);
        bus.Addr  = 3'(ADDR_RESULT);
        bus.RD    = 1'b1;
        res_valid = 1'b1;
        res_data  = push_val;
        tick();
        res_valid = 1'b0;
        chk(tag, bus.DataOut, exp);
        tick();
        bus.RD = 1'b0;
        tick();
        chk({tag, "_hold"}, bus.DataOut, exp);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        busy       = 1'b0;
        res_valid  = 1'b0;
        res_data   = '0;
        bus.RD     = 1'b0;
        bus.WR     = 1'b0;
        bus.Addr   = '0;
        bus.DataIn = '0;
        tick();
        tick();
        chk("rst_dataout", bus.DataOut, 16'h0);
        chk("rst_start", start, 1'b0);
        chk("rst_resready", res_ready, 1'b1);
        chk("rst_arg0", arg0, 16'h0);
        rst = 1'b0;
        tick();
        rd_chk("rst_status", ADDR_STATUS, 1, 16'h0004);

        // Reset in the middle of a two-cycle RESULT read
        push_word(16'h0055);
        push_word(16'h0066);
        rd_chk("mid_status", ADDR_STATUS, 1, 16'h0200);
        bus.Addr = 3'(ADDR_RESULT);
        bus.RD   = 1'b1;
        tick();
        chk("mid_pop", bus.DataOut, 16'h0055);
        rst = 1'b1;
        #2;
        chk("mid_rst_dataout", bus.DataOut, 16'h0);
        chk("mid_rst_resready", res_ready, 1'b1);
        bus.RD = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        rd_chk("mid_after_status", ADDR_STATUS, 1, 16'h0004);
        push_word(16'h0077);
        rd_chk("mid_one_status", ADDR_STATUS, 1, 16'h0100);
        rd_chk("mid_result", ADDR_RESULT, 2, 16'h0077);
        rd_chk("mid_empty_status", ADDR_STATUS, 1, 16'h0004);

        // Argument registers and unmapped addresses
        wr(ADDR_ARG0, 16'h1234);
        chk("arg0_port", arg0, 16'h1234);
        rd_chk("arg0_read", ADDR_ARG0, 2, 16'h1234);
        wr(ADDR_ARG1, 16'hBEEF);
        chk("arg1_port", arg1, 16'hBEEF);
        rd_chk("arg1_read", ADDR_ARG1, 3, 16'hBEEF);
        wr(6, 16'hFFFF);
        wr(ADDR_STATUS, 16'hFFFF);
        chk("unmapped_arg0", arg0, 16'h1234);
        chk("unmapped_arg1", arg1, 16'hBEEF);
        rd_chk("read_addr5", 5, 1, 16'h0);
        rd_chk("read_addr7", 7, 2, 16'h0);
        rd_chk("read_ctrl", ADDR_CTRL, 1, 16'h0);

        // RD and WR together: write wins, DataOut keeps the previous read
        rd_chk("pre_rdwr", ADDR_ARG1, 1, 16'hBEEF);
        bus.Addr   = 3'(ADDR_ARG0);
        bus.DataIn = 16'h4321;
        bus.RD     = 1'b1;
        bus.WR     = 1'b1;
        tick();
        bus.RD = 1'b0;
        bus.WR = 1'b0;
        chk("rdwr_arg0", arg0, 16'h4321);
        chk("rdwr_dataout", bus.DataOut, 16'hBEEF);
        tick();

        // Three results drained in order, count stepping down
        push_word(16'h000A);
        push_word(16'h000B);
        push_word(16'h000C);
        rd_chk("three_status", ADDR_STATUS, 1, 16'h0300);
        rd_chk("res_a", ADDR_RESULT, 2, 16'h000A);
        rd_chk("cnt2_status", ADDR_STATUS, 1, 16'h0200);
        rd_chk("res_b", ADDR_RESULT, 2, 16'h000B);
        rd_chk("cnt1_status", ADDR_STATUS, 1, 16'h0100);
        rd_chk("res_c", ADDR_RESULT, 2, 16'h000C);
        rd_chk("cnt0_status", ADDR_STATUS, 1, 16'h0004);

        // Fill, push-while-full, simultaneous push/pop, wrap-around drain
        for (int i = 1; i <= 8; i++) push_word(16'(16'h0100 + i));
        chk("full_resready", res_ready, 1'b0);
        rd_chk("full_status", ADDR_STATUS, 1, 16'h0808);
        push_word(16'h0999);
        rd_chk("full_push_ignored", ADDR_STATUS, 1, 16'h0808);
        rd_push("full_pop_push", 16'h0999, 16'h0101);
        rd_chk("after_full_pop", ADDR_STATUS, 1, 16'h0700);
        rd_push("cnt7_pop_push", 16'h0200, 16'h0102);
        rd_chk("cnt7_status", ADDR_STATUS, 1, 16'h0700);
        for (int i = 3; i <= 8; i++) rd_chk("drain", ADDR_RESULT, 2, 16'(16'h0100 + i));
        rd_chk("drain_last", ADDR_RESULT, 2, 16'h0200);
        rd_chk("drained_status", ADDR_STATUS, 1, 16'h0004);

        // Underflow and flush
        rd_chk("underflow_data", ADDR_RESULT, 2, 16'h0);
        rd_chk("underflow_status", ADDR_STATUS, 1, 16'h0014);
        wr(ADDR_CTRL, 16'h0002);
        rd_chk("flush_status", ADDR_STATUS, 1, 16'h0004);
        push_word(16'h0033);
        res_valid = 1'b1;
        res_data  = 16'h0044;
        wr(ADDR_CTRL, 16'h0002);
        res_valid = 1'b0;
        rd_chk("flush_push_status", ADDR_STATUS, 1, 16'h0004);

        // Start / Busy / Done handshake
        wr(ADDR_CTRL, 16'h0001);
        chk("start_pulse", start, 1'b1);
        tick();
        chk("start_one_cycle", start, 1'b0);
        wr(ADDR_CTRL, 16'h0004);
        chk("irq_en_no_start", start, 1'b0);
        rd_chk("ctrl_readback", ADDR_CTRL, 1, CTRL_RB);
        busy = 1'b1;
        tick();
        rd_chk("busy_status", ADDR_STATUS, 1, 16'h0005);
        busy = 1'b0;
        tick();
        rd_chk("done_status", ADDR_STATUS, 1, 16'h0006);
`ifdef PBUS_HOST_REGS_IRQ_EN
        chk("irq_high", irq, 1'b1);
`endif
        busy = 1'b1;
        tick();
        wr(ADDR_CTRL, 16'h0001);
        chk("busy_start_dropped", start, 1'b0);
        tick();
        chk("busy_start_still_low", start, 1'b0);
        rd_chk("busy_done_status", ADDR_STATUS, 1, 16'h0007);
        busy = 1'b0;
        tick();
        tick();
        wr(ADDR_CTRL, 16'h0001);
        chk("start_again", start, 1'b1);
        rd_chk("done_cleared_status", ADDR_STATUS, 1, 16'h0004);
`ifdef PBUS_HOST_REGS_IRQ_EN
        chk("irq_low", irq, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
